// File: rtl/seg_pkg.sv
// -----------------------------------------------------------------------------
// seg_pkg
// Shared definitions for the seven-segment serial transmitter path.
//   seg_state_t   : transmitter FSM states (IDLE, SHIFT, LATCH)
//   SEG_FRAME_W   : segment frame width (8 digits x 8 segments)
//   SEG_BIT_CNT_W : width of the bit counter that walks one frame
// -----------------------------------------------------------------------------
package seg_pkg;

    localparam int SEG_FRAME_W   = 64;
    localparam int SEG_BIT_CNT_W = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } seg_state_t;

endpackage

// File: rtl/seg_clk_div.sv
// -----------------------------------------------------------------------------
// seg_clk_div
// Half-period divider for the display shift clock. It counts DIV cycles per
// half-period and flags the last cycle of each half with a strobe. The
// strobes are combinational, and the owner registers them into seg_clk.
//   clk         : system clock
//   rst         : synchronous active-high reset
//   i_clr       : synchronous clear (frame start), restarts a low half-period
//   i_en        : count enable (transmitter busy)
//   o_rise_tick : last cycle of a low half, seg_clk goes high next cycle
//   o_fall_tick : last cycle of a high half, seg_clk goes low next cycle
// -----------------------------------------------------------------------------
module seg_clk_div #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_rise_tick,
    output logic o_fall_tick
);

    localparam int               CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_hi;
    logic             w_wrap;

    assign w_wrap      = i_en && (r_cnt == LAST);
    assign o_rise_tick = w_wrap && !r_hi;
    assign o_fall_tick = w_wrap &&  r_hi;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
            r_hi  <= 1'b0;
        end else if (i_en) begin
            if (r_cnt == LAST) begin
                r_cnt <= '0;
                r_hi  <= !r_hi;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg_serial_tx.sv
// -----------------------------------------------------------------------------
// seg_serial_tx
// Shifts a 64-bit seven-segment frame MSB first into the board's cascaded
// shift-register chain, then latches it onto the display.
//   clk      : system clock
//   rst      : synchronous active-high reset
//   start    : transmit request, sampled only while idle
//   seg_txt  : segment frame {p,g,f,e,d,c,b,a} per digit, digit 0 in [7:0]
//   busy     : high while shifting or latching
//   done     : one-cycle pulse on the first idle cycle after the latch
//   seg_clk  : chain shift clock, the chain samples on its rising edge
//   seg_dat  : serial data
//   seg_pen  : display enable, held low while shifting to avoid ghosting
//   seg_clrn : chain clear, active-low, released on the first frame
// Build option: defining SEG_AUTO_REFRESH_EN keeps a copy of the last frame
// sent and starts a transmission by itself whenever seg_txt differs from it.
// -----------------------------------------------------------------------------
module seg_serial_tx
    import seg_pkg::*;
#(
    parameter int DIV     = 2,
    parameter int FRAME_W = SEG_FRAME_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [FRAME_W-1:0] seg_txt,
    output logic               busy,
    output logic               done,
    output logic               seg_clk,
    output logic               seg_dat,
    output logic               seg_pen,
    output logic               seg_clrn
);

    seg_state_t               r_state;
    logic [FRAME_W-1:0]       r_shift;
    logic [SEG_BIT_CNT_W-1:0] r_bit_cnt;

    logic w_go;
    logic w_entry;
    logic w_last_bit;
    logic w_rise_tick;
    logic w_fall_tick;

`ifdef SEG_AUTO_REFRESH_EN
    // The copy resets to all-ones so the first frame after reset always
    // looks new and is pushed to the display without a start request.
    logic [FRAME_W-1:0] r_last;

    assign w_go = start || (seg_txt != r_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= '1;
        end else if (w_entry) begin
            r_last <= seg_txt;
        end
    end
`else
    assign w_go = start;
`endif

    assign w_entry    = (r_state == IDLE) && w_go;
    assign w_last_bit = (r_bit_cnt == SEG_BIT_CNT_W'(FRAME_W - 1));

    // The divider runs through LATCH as well, so one low half plus one high
    // half (2*DIV cycles) times the latch phase with no extra counter.
    seg_clk_div #(
        .DIV (DIV)
    ) u_clk_div (
        .clk         (clk),
        .rst         (rst),
        .i_clr       (w_entry),
        .i_en        (r_state != IDLE),
        .o_rise_tick (w_rise_tick),
        .o_fall_tick (w_fall_tick)
    );

    // The frame is data only. It is reloaded on every frame start, so it has
    // no reset. r_shift[FRAME_W-1] is always the bit currently on seg_dat.
    always_ff @(posedge clk) begin
        if (w_entry) begin
            r_shift <= seg_txt;
        end else if ((r_state == SHIFT) && w_fall_tick) begin
            r_shift <= {r_shift[FRAME_W-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_bit_cnt <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            seg_clk   <= 1'b0;
            seg_dat   <= 1'b0;
            seg_pen   <= 1'b0;
            seg_clrn  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_go) begin
                        r_state   <= SHIFT;
                        r_bit_cnt <= '0;
                        busy      <= 1'b1;
                        seg_clk   <= 1'b0;
                        seg_dat   <= seg_txt[FRAME_W-1];
                        seg_pen   <= 1'b0;
                        seg_clrn  <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (w_rise_tick) begin
                        seg_clk <= 1'b1;
                    end else if (w_fall_tick) begin
                        // Next bit goes out on the falling edge, so it is stable
                        // for the whole low half before the chain samples it.
                        seg_clk   <= 1'b0;
                        seg_dat   <= r_shift[FRAME_W-2];
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        if (w_last_bit) begin
                            r_state <= LATCH;
                            seg_pen <= 1'b1;
                        end
                    end
                end
                LATCH: begin
                    if (w_fall_tick) begin
                        r_state <= IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg_serial_tx.sv
`timescale 1ns/1ps
module tb_seg_serial_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        a_start, b_start;
    logic [63:0] a_txt, b_txt;
    logic        a_busy, a_done, a_seg_clk, a_seg_dat, a_seg_pen, a_seg_clrn;
    logic        b_busy, b_done, b_seg_clk, b_seg_dat, b_seg_pen, b_seg_clrn;

    seg_serial_tx #(.DIV(2), .FRAME_W(64)) u_a (
        .clk(clk), .rst(rst), .start(a_start), .seg_txt(a_txt),
        .busy(a_busy), .done(a_done), .seg_clk(a_seg_clk), .seg_dat(a_seg_dat),
        .seg_pen(a_seg_pen), .seg_clrn(a_seg_clrn)
    );

    seg_serial_tx #(.DIV(1), .FRAME_W(64)) u_b (
        .clk(clk), .rst(rst), .start(b_start), .seg_txt(b_txt),
        .busy(b_busy), .done(b_done), .seg_clk(b_seg_clk), .seg_dat(b_seg_dat),
        .seg_pen(b_seg_pen), .seg_clrn(b_seg_clrn)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Scoreboards: expected frames pushed at stimulus, received frames pushed
    // by the chain monitors when done pulses.
    logic [63:0] a_exp[$], a_got[$], b_exp[$], b_got[$];
    int          a_rise_q[$], b_rise_q[$];
    int          a_done_cnt = 0, b_done_cnt = 0;

    // Chain model for instance A: shift in seg_dat at every seg_clk rise.
    initial begin : mon_a
        logic [63:0] sh;
        logic        prev;
        int          rises;
        sh = '0; prev = 1'b0; rises = 0;
        forever begin
            @(negedge clk);
            if (a_seg_clk && !prev) begin
                sh = {sh[62:0], a_seg_dat};
                rises++;
            end
            prev = a_seg_clk;
            if (a_done) begin
                a_got.push_back(sh);
                a_rise_q.push_back(rises);
                a_done_cnt++;
                rises = 0;
            end else if (!a_busy) begin
                rises = 0;
            end
        end
    end

    initial begin : mon_b
        logic [63:0] sh;
        logic        prev;
        int          rises;
        sh = '0; prev = 1'b0; rises = 0;
        forever begin
            @(negedge clk);
            if (b_seg_clk && !prev) begin
                sh = {sh[62:0], b_seg_dat};
                rises++;
            end
            prev = b_seg_clk;
            if (b_done) begin
                b_got.push_back(sh);
                b_rise_q.push_back(rises);
                b_done_cnt++;
                rises = 0;
            end else if (!b_busy) begin
                rises = 0;
            end
        end
    end

    task automatic pop_a(output logic ok, output logic [63:0] got, output logic [63:0] exp,
                         output int rises);
        ok = (a_got.size() > 0) && (a_exp.size() > 0) && (a_rise_q.size() > 0);
        got = '0; exp = '0; rises = 0;
        if (ok) begin
            got   = a_got.pop_front();
            exp   = a_exp.pop_front();
            rises = a_rise_q.pop_front();
        end
    endtask

    task automatic pop_b(output logic ok, output logic [63:0] got, output logic [63:0] exp,
                         output int rises);
        ok = (b_got.size() > 0) && (b_exp.size() > 0) && (b_rise_q.size() > 0);
        got = '0; exp = '0; rises = 0;
        if (ok) begin
            got   = b_got.pop_front();
            exp   = b_exp.pop_front();
            rises = b_rise_q.pop_front();
        end
    endtask

    task automatic test_reset();
        logic [11:0] obs;
        string       nm[12];
        nm = '{"a_busy", "a_done", "a_seg_clk", "a_seg_dat", "a_seg_pen", "a_seg_clrn",
               "b_busy", "b_done", "b_seg_clk", "b_seg_dat", "b_seg_pen", "b_seg_clrn"};
        rst = 1'b1; a_start = 1'b0; b_start = 1'b0;
        a_txt = 64'hFF; b_txt = 64'h8000_0000_0000_0001;
        repeat (3) @(negedge clk);
        obs = {a_busy, a_done, a_seg_clk, a_seg_dat, a_seg_pen, a_seg_clrn,
               b_busy, b_done, b_seg_clk, b_seg_dat, b_seg_pen, b_seg_clrn};
        for (int i = 0; i < 12; i++) begin
            n_tests++;
            if (obs[11-i] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_%s: got %b want 0", nm[i], obs[11-i]);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [63:0] f, got, exp;
        logic        ok, prev, pen_bad, pen_latch;
        int          n, first_rise, rises;
        f = 64'h0123_4567_89AB_CDEF;
        a_txt = f; a_start = 1'b1; a_exp.push_back(f);
        @(negedge clk); a_start = 1'b0; n = 1;
        n_tests++;
        if (a_busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_c1: got %b want 1", a_busy); end
        n_tests++;
        if (a_seg_dat !== f[63]) begin n_fail++; $display("FAIL basic_dat_c1: got %b want %b", a_seg_dat, f[63]); end
        n_tests++;
        if (a_seg_clrn !== 1'b1) begin n_fail++; $display("FAIL basic_clrn: got %b want 1", a_seg_clrn); end
        first_rise = 0; pen_bad = 1'b0; pen_latch = 1'b0; prev = a_seg_clk;
        while (!a_done && n < 400) begin
            @(negedge clk); n++;
            if (first_rise == 0 && a_seg_clk && !prev) first_rise = n;
            prev = a_seg_clk;
            if (n <= 256 && a_seg_pen) pen_bad = 1'b1;
            if (n == 257) pen_latch = a_seg_pen;
        end
        n_tests++;
        if (first_rise !== 3) begin n_fail++; $display("FAIL basic_first_rise: got cycle %0d want 3", first_rise); end
        n_tests++;
        if (pen_bad !== 1'b0) begin n_fail++; $display("FAIL basic_pen_shift: seg_pen high during SHIFT"); end
        n_tests++;
        if (pen_latch !== 1'b1) begin n_fail++; $display("FAIL basic_pen_latch: got %b want 1 at cycle 257", pen_latch); end
        n_tests++;
        if (n !== 261) begin n_fail++; $display("FAIL basic_done_cycle: got %0d want 261", n); end
        n_tests++;
        if (a_busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_end: got %b want 0", a_busy); end
        @(negedge clk);
        n_tests++;
        if (a_done !== 1'b0) begin n_fail++; $display("FAIL basic_done_width: got %b want 0", a_done); end
        pop_a(ok, got, exp, rises);
        n_tests++;
        if (!ok) begin
            n_fail++; $display("FAIL basic_frame: no frame captured");
        end else begin
            if (got !== exp) begin n_fail++; $display("FAIL basic_frame: got %h want %h", got, exp); end
            n_tests++;
            if (rises !== 64) begin n_fail++; $display("FAIL basic_rises: got %0d want 64", rises); end
        end
    endtask

    task automatic test_ignore_start();
        logic [63:0] f, got, exp;
        logic        ok;
        int          n, d0, rises;
        f = 64'h5A5A_0F0F_3C3C_9669;
        d0 = a_done_cnt;
        a_txt = f; a_start = 1'b1; a_exp.push_back(f);
        @(negedge clk); a_start = 1'b0; n = 1;
        repeat (48) begin @(negedge clk); n++; end
        a_txt = 64'hFFFF_FFFF_FFFF_FFFF; a_start = 1'b1;
        @(negedge clk); a_start = 1'b0; n++;
        while (!a_done && n < 400) begin @(negedge clk); n++; end
        n_tests++;
        if (n !== 261) begin n_fail++; $display("FAIL ignore_done_cycle: got %0d want 261", n); end
        repeat (300) @(negedge clk);
        n_tests++;
        if (a_done_cnt - d0 !== 1) begin n_fail++; $display("FAIL ignore_done_count: got %0d want 1", a_done_cnt - d0); end
        pop_a(ok, got, exp, rises);
        n_tests++;
        if (!ok) begin
            n_fail++; $display("FAIL ignore_frame: no frame captured");
        end else if (got !== exp) begin
            n_fail++; $display("FAIL ignore_frame: got %h want %h", got, exp);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] got, exp;
        logic        ok, pen_bad;
        int          k, rises;
        a_txt = 64'hC0; a_start = 1'b1;
        for (int fr = 0; fr < 3; fr++) begin
            a_exp.push_back(64'hC0);
            k = 0; pen_bad = 1'b0;
            do begin
                @(negedge clk); k++;
                if (k <= 256 && a_seg_pen) pen_bad = 1'b1;
            end while (!a_done && k < 400);
            n_tests++;
            if (k !== 261) begin n_fail++; $display("FAIL b2b_period%0d: got %0d want 261", fr, k); end
            n_tests++;
            if (pen_bad !== 1'b0) begin n_fail++; $display("FAIL b2b_pen%0d: seg_pen high during SHIFT", fr); end
        end
        a_start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (a_busy !== 1'b0) begin n_fail++; $display("FAIL b2b_stop: got busy %b want 0", a_busy); end
        for (int fr = 0; fr < 3; fr++) begin
            pop_a(ok, got, exp, rises);
            n_tests++;
            if (!ok) begin
                n_fail++; $display("FAIL b2b_frame%0d: no frame captured", fr);
            end else if (got !== exp || rises !== 64) begin
                n_fail++; $display("FAIL b2b_frame%0d: got %h/%0d rises want %h/64", fr, got, rises, exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        int d0;
        a_txt = 64'hDEAD_BEEF_0000_FFFF; a_start = 1'b1;
        @(negedge clk); a_start = 1'b0;
        repeat (99) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_tests++;
        if (a_seg_pen !== 1'b0) begin n_fail++; $display("FAIL rstmid_pen: got %b want 0", a_seg_pen); end
        n_tests++;
        if (a_seg_clrn !== 1'b0) begin n_fail++; $display("FAIL rstmid_clrn: got %b want 0", a_seg_clrn); end
        n_tests++;
        if (a_busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", a_busy); end
        n_tests++;
        if ({a_seg_clk, a_seg_dat} !== 2'b00) begin
            n_fail++; $display("FAIL rstmid_clkdat: got %b want 00", {a_seg_clk, a_seg_dat});
        end
        d0 = a_done_cnt;
        repeat (300) @(negedge clk);
        n_tests++;
        if (a_done_cnt - d0 !== 0 || a_got.size() !== 0) begin
            n_fail++; $display("FAIL rstmid_no_done: got %0d dones want 0", a_done_cnt - d0);
        end
    endtask

    task automatic test_div1();
        logic [63:0] f, got, exp;
        logic        ok, prev;
        int          n, first_rise, rises;
        f = 64'h8000_0000_0000_0001;
        b_txt = f; b_start = 1'b1; b_exp.push_back(f);
        @(negedge clk); b_start = 1'b0; n = 1;
        n_tests++;
        if (b_seg_dat !== 1'b1) begin n_fail++; $display("FAIL div1_first_bit: got %b want 1", b_seg_dat); end
        first_rise = 0; prev = b_seg_clk;
        while (!b_done && n < 200) begin
            @(negedge clk); n++;
            if (first_rise == 0 && b_seg_clk && !prev) first_rise = n;
            prev = b_seg_clk;
        end
        n_tests++;
        if (first_rise !== 2) begin n_fail++; $display("FAIL div1_first_rise: got %0d want 2", first_rise); end
        n_tests++;
        if (n !== 131) begin n_fail++; $display("FAIL div1_done_cycle: got %0d want 131", n); end
        @(negedge clk);
        pop_b(ok, got, exp, rises);
        n_tests++;
        if (!ok) begin
            n_fail++; $display("FAIL div1_frame: no frame captured");
        end else begin
            if (got !== exp) begin n_fail++; $display("FAIL div1_frame: got %h want %h", got, exp); end
            n_tests++;
            if (rises !== 64) begin n_fail++; $display("FAIL div1_rises: got %0d want 64", rises); end
        end
    endtask

    task automatic test_no_start();
        int d0;
        d0 = a_done_cnt;
        a_txt = 64'h1234_5678_0000_0000;
        repeat (300) @(negedge clk);
        n_tests++;
        if (a_done_cnt - d0 !== 0 || a_busy !== 1'b0) begin
            n_fail++; $display("FAIL no_start: got %0d dones busy %b want 0/0", a_done_cnt - d0, a_busy);
        end
    endtask

    task automatic test_auto_refresh();
        logic [63:0] got, exp;
        logic        ok;
        int          d0, rises;
        // a_txt is already 64'hFF from reset; nothing pulses start here.
        a_exp.push_back(64'hFF);
        d0 = a_done_cnt;
        repeat (700) @(negedge clk);
        n_tests++;
        if (a_done_cnt - d0 !== 1) begin n_fail++; $display("FAIL auto_first_count: got %0d want 1", a_done_cnt - d0); end
        pop_a(ok, got, exp, rises);
        n_tests++;
        if (!ok) begin
            n_fail++; $display("FAIL auto_first_frame: no frame captured");
        end else if (got !== exp) begin
            n_fail++; $display("FAIL auto_first_frame: got %h want %h", got, exp);
        end
        a_txt = 64'hFE; a_exp.push_back(64'hFE);
        d0 = a_done_cnt;
        repeat (700) @(negedge clk);
        n_tests++;
        if (a_done_cnt - d0 !== 1) begin n_fail++; $display("FAIL auto_second_count: got %0d want 1", a_done_cnt - d0); end
        pop_a(ok, got, exp, rises);
        n_tests++;
        if (!ok) begin
            n_fail++; $display("FAIL auto_second_frame: no frame captured");
        end else if (got !== exp) begin
            n_fail++; $display("FAIL auto_second_frame: got %h want %h", got, exp);
        end
    endtask

    initial begin : watchdog
        #500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        test_reset();
`ifdef SEG_AUTO_REFRESH_EN
        test_auto_refresh();
        test_basic();
        test_back_to_back();
`else
        test_basic();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_div1();
        test_no_start();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_serial_tx.md
# seg_serial_tx

Serial transmitter for the eight-digit seven-segment display path. It captures the 64-bit segment frame produced by the hex-to-segment encoder: eight bytes, `{p,g,f,e,d,c,b,a}` per digit, digit 0 in bits [7:0]. It then shifts the frame out bit-serially to the board's cascaded shift-register chain and latches it onto the display. It sits between the segment encoder and the board pins and is the only driver of the display's serial interface.

## Interface
Parameters:
- `DIV`, default 2: number of `clk` cycles per `seg_clk` half-period; legal range ≥ 1.
- `FRAME_W`, default 64: frame width in bits; fixed at 64 for this board.

Ports:
- `clk`, input, 1: system clock; the only clock.
- `rst`, input, 1: reset; synchronous, active-high.
- `start`, input, 1: request to transmit `seg_txt`; sampled only in IDLE.
- `seg_txt`, input, 64: segment frame, same bit layout as the encoder output.
- `busy`, output, 1: transmission in progress.
- `done`, output, 1: one-cycle pulse when a frame is latched on the display.
- `seg_clk`, output, 1: shift clock to the chain; data is sampled by the chain on the rising edge.
- `seg_dat`, output, 1: serial data.
- `seg_pen`, output, 1: display output enable; 1 shows the latched frame.
- `seg_clrn`, output, 1: chain clear, active-low.

## Operation
- Reset values:
  - `busy` = 0, `done` = 0, `seg_clk` = 0, `seg_dat` = 0
  - `seg_pen` = 0 (display blank until the first frame)
  - `seg_clrn` = 0
  - state = IDLE, counters = 0
- IDLE, with `start` = 1:
  - Load `seg_txt` into the 64-bit shift register.
  - Set `seg_clrn` = 1 (it stays 1 until the next reset).
  - Go to SHIFT.
- SHIFT:
  - Bits are sent MSB first: bit 63 first, bit 0 last.
  - Each bit takes `DIV` cycles with `seg_clk` = 0 and `seg_dat` stable, then `DIV` cycles with `seg_clk` = 1.
  - `seg_dat` changes only on the cycle `seg_clk` falls, or on SHIFT entry.
  - `seg_pen` = 0 throughout SHIFT, to suppress ghosting.
- The 6-bit bit counter counts 0..63. Wrap from 63 to 0 at the end of the last high phase moves the state to LATCH.
- LATCH:
  - `seg_clk` = 0, `seg_pen` = 1, lasting 2·`DIV` cycles.
  - Then go to IDLE and pulse `done` on the first IDLE cycle.
- `busy` = 1 in SHIFT and LATCH, 0 in IDLE.
- `start` while `busy` = 1 is ignored, with no queueing. `start` in the cycle `done` pulses is accepted, because the state is already IDLE.
- `seg_txt` changing during SHIFT has no effect; the frame captured at the start edge is the one sent.
- `rst` mid-frame: all outputs return to their reset values on the next edge, the display blanks, and the partial frame is discarded.

## Timing
- `start` sampled at edge 0: `busy` = 1 and `seg_dat` = bit 63 from cycle 1.
- First `seg_clk` rise at cycle 1+`DIV`.
- SHIFT lasts 128·`DIV` cycles.
- `seg_pen` rises at cycle 128·`DIV`+1.
- `busy` falls and `done` pulses at cycle 130·`DIV`+1.
- With `DIV` = 2: 64 rises, `done` at cycle 261.
- Back-to-back frames: the next frame's SHIFT can begin on the cycle after `done`.

## Configuration
- `SEG_AUTO_REFRESH_EN` defined:
  - The block keeps a 64-bit copy of the last transmitted frame.
  - In IDLE, if `seg_txt` differs from the copy, a transmission starts exactly as for `start`.
  - `start` still forces retransmission.
  - The copy resets to all-ones, which differs from any frame the encoder produces during reset, so the first frame after reset is sent automatically.
- Not defined: transmission occurs only on `start`, and no copy register exists.

## Structure
- Shared package `seg_pkg`:
  - state enum: IDLE, SHIFT, LATCH
  - `SEG_FRAME_W` = 64
  - `SEG_BIT_CNT_W` = 6
- Sub-module `seg_clk_div`: a `DIV` counter emitting `fall_tick` and `rise_tick` strobes, synchronously cleared on `rst` or on SHIFT entry.
- Top-level: FSM, shift register, bit counter, output registers. All outputs are registered.

## Test plan
- Reset with `DIV` = 2 → all outputs at reset values; `start` pulse with `seg_txt` = 64'h0123_4567_89AB_CDEF → 64 `seg_clk` rises, and sampled bits at the rises reconstruct 64'h0123_4567_89AB_CDEF MSB first; `done` at cycle 261.
- During SHIFT, change `seg_txt` to 64'hFFFF_FFFF_FFFF_FFFF and pulse `start` → transmitted frame unchanged, exactly one `done`.
- `start` held high continuously with `seg_txt` = 64'hC0 → frames back-to-back; `done` every 261 cycles; `seg_pen` = 0 during each SHIFT.
- Assert `rst` at cycle 100 of a frame → next cycle `seg_pen` = 0, `seg_clrn` = 0, `busy` = 0, and no `done`.
- `DIV` = 1, `seg_txt` = 64'h8000_0000_0000_0001 → `seg_dat` = 1 for the first bit and the last bit only; `done` at cycle 131.
- `SEG_AUTO_REFRESH_EN` defined, no `start`: after reset, hold `seg_txt` constant at 64'hFF → exactly one frame sent. Change to 64'hFE → exactly one more frame sent.
